// File: rtl/byte_striping_n.sv
// byte_striping_n: distributes a stream of input words round-robin across
// LANES output lanes. A runtime enable mask skips lanes, and a realign
// pulse restarts the rotation at the lowest enabled lane. Every output is
// registered, so a word appears on its lane one clk_2f cycle after it is
// sampled.
module byte_striping_n #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic                         clk_2f,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [WIDTH-1:0]             Data_in,
  input  logic [LANES-1:0]             lane_en,
  input  logic                         realign,
  output logic [LANES-1:0]             valid_out,
  output logic [LANES*WIDTH-1:0]       lane_out,
  output logic                         stripe_end,
  output logic                         drop,
  output logic [$clog2(LANES)-1:0]     ptr_out
);

  localparam int PW = $clog2(LANES);

  logic [PW-1:0]          ptr_q,   ptr_d;
  logic [LANES-1:0]       valid_q, valid_d;
  logic [LANES*WIDTH-1:0] lane_q,  lane_d;
  logic                   end_q,   end_d;
  logic                   drop_q,  drop_d;

  logic [PW-1:0]          start_s;
  logic [PW-1:0]          target_s;
  logic                   found_s;
  logic [PW-1:0]          hi_s;

  // Find the first enabled lane at or above the start index, wrapping around.
  always_comb begin
    start_s  = realign ? {PW{1'b0}} : ptr_q;
    found_s  = 1'b0;
    target_s = {PW{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      int idx;
      idx = int'(start_s) + k;
      if (idx >= LANES) begin
        idx = idx - LANES;
      end else begin
        idx = idx;
      end
      if (!found_s && lane_en[idx]) begin
        found_s  = 1'b1;
        target_s = PW'(idx);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Index of the highest enabled lane; a word landing there closes a stripe.
  always_comb begin
    hi_s = {PW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) begin
        hi_s = PW'(i);
      end else begin
        hi_s = hi_s;
      end
    end
  end

  // Next-state for pointer, lane registers and the per-word status flags.
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = {LANES{1'b0}};
    lane_d  = lane_q;
    end_d   = 1'b0;
    drop_d  = 1'b0;
    if (valid_in && found_s) begin
      lane_d[int'(target_s)*WIDTH +: WIDTH] = Data_in;
      valid_d = {{(LANES-1){1'b0}}, 1'b1} << target_s;
      end_d   = (target_s == hi_s);
      if (target_s == PW'(LANES-1)) begin
        ptr_d = {PW{1'b0}};
      end else begin
        ptr_d = target_s + PW'(1);
      end
    end else if (valid_in) begin
      // No lane enabled: the word has nowhere to go and is discarded.
      drop_d = 1'b1;
      ptr_d  = realign ? {PW{1'b0}} : ptr_q;
    end else begin
      ptr_d  = realign ? {PW{1'b0}} : ptr_q;
    end
  end

  // State registers; reset clears everything, discarding any in-flight word.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      ptr_q   <= {PW{1'b0}};
      valid_q <= {LANES{1'b0}};
      lane_q  <= {(LANES*WIDTH){1'b0}};
      end_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      lane_q  <= lane_d;
      end_q   <= end_d;
      drop_q  <= drop_d;
    end
  end

  assign valid_out  = valid_q;
  assign lane_out   = lane_q;
  assign stripe_end = end_q;
  assign drop       = drop_q;
  assign ptr_out    = ptr_q;

endmodule
